trace_checker: RTL and testbench

Hardware trace reader. It consumes a golden per-step trace stream of pc, instruction and all 32 GPRs, and compares each frame against a snapshot of the live core. Mismatches are counted and the first divergence is recorded. It sits in the SoC verification shell next to `core0`: snapshot inputs tap the core's IMEM address, IMEM read data and `gpr_inst` register array, and the golden stream comes from a trace ROM or DMA.

---
 rtl/trace_checker.sv | 129 ++++++++++++
 tb/tb_trace_checker.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_checker.sv
// trace_checker: latches a live core snapshot (pc, inst, 32 GPRs) and
// compares it word by word against a 34-word golden trace frame.
// Ports: base_clk/reset (sync, active-high); step_valid/step_ready plus
//   snap_pc/snap_inst/snap_gpr snapshot in; gold_valid/gold_data/
//   gold_ready golden stream in; frame_cnt, mismatch_cnt (saturating),
//   first_err_* (first divergence record) and done status out.
// Option: define TRACE_CHECK_STOP_ON_ERR_EN to halt on the first mismatch.
module trace_checker #(
  parameter int NUM_FRAMES = 4096,
  parameter int CNT_W      = 16
) (
  input  logic             base_clk,
  input  logic             reset,
  input  logic             step_valid,
  output logic             step_ready,
  input  logic [31:0]      snap_pc,
  input  logic [31:0]      snap_inst,
  input  logic [1023:0]    snap_gpr,
  input  logic             gold_valid,
  input  logic [31:0]      gold_data,
  output logic             gold_ready,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_frame,
  output logic [5:0]       first_err_idx,
  output logic [31:0]      first_err_got,
  output logic [31:0]      first_err_exp,
  output logic             done
);

  localparam int WORDS = 34;
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(NUM_FRAMES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [31:0] snap [WORDS];
  logic [5:0] idx;
  logic take, fire, miss, last, halt;
  logic [CNT_W-1:0] frame_inc;

  assign take = step_valid && (state == S_IDLE);
  assign fire = gold_valid && (state == S_CMP);
  assign miss = fire && (gold_data != snap[idx]);
  assign last = fire && (idx == 6'd33);
  assign frame_inc = frame_cnt + 1'b1;

`ifdef TRACE_CHECK_STOP_ON_ERR_EN
  assign halt = miss;
`else
  assign halt = 1'b0;
`endif

  always_ff @(posedge base_clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (take) state_nxt = S_CMP;
      S_CMP: begin
        if (halt)
          state_nxt = S_DONE;
        else if (last)
          state_nxt = (frame_inc == LAST_FRAME) ? S_DONE : S_IDLE;
      end
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    step_ready = (state == S_IDLE);
    gold_ready = (state == S_CMP);
    done       = (state == S_DONE);
  end

  // Snapshot buffer needs no reset: it is always rewritten before use.
  always_ff @(posedge base_clk) begin
    if (take) begin
      snap[0] <= snap_pc;
      snap[1] <= snap_inst;
      for (int i = 0; i < 32; i++)
        snap[i+2] <= snap_gpr[32*i +: 32];
    end
  end

  always_ff @(posedge base_clk) begin
    if (reset) begin
      idx             <= '0;
      frame_cnt       <= '0;
      mismatch_cnt    <= '0;
      first_err_valid <= 1'b0;
      first_err_frame <= '0;
      first_err_idx   <= '0;
      first_err_got   <= '0;
      first_err_exp   <= '0;
    end else begin
      if (take) idx <= '0;
      if (fire) begin
        idx <= last ? 6'd0 : idx + 6'd1;
        if (miss) begin
          if (mismatch_cnt != CNT_MAX)
            mismatch_cnt <= mismatch_cnt + 1'b1;
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_frame <= frame_cnt;
            first_err_idx   <= idx;
            first_err_got   <= snap[idx];
            first_err_exp   <= gold_data;
          end
        end
        // A halting mismatch leaves the partial frame uncounted.
        if (last && !halt)
          frame_cnt <= frame_inc;
      end
    end
  end

endmodule

// File: tb/tb_trace_checker.sv
// tb_trace_checker: directed scoreboard bench for trace_checker.
// Driver pushes expected status per golden word; monitor pops on consume.
module tb_trace_checker;

  localparam int CW = 16;

  logic          base_clk = 1'b0;
  logic          reset;
  logic          step_valid;
  logic          step_ready;
  logic [31:0]   snap_pc;
  logic [31:0]   snap_inst;
  logic [1023:0] snap_gpr;
  logic          gold_valid;
  logic [31:0]   gold_data;
  logic          gold_ready;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] mismatch_cnt;
  logic          first_err_valid;
  logic [CW-1:0] first_err_frame;
  logic [5:0]    first_err_idx;
  logic [31:0]   first_err_got;
  logic [31:0]   first_err_exp;
  logic          done;

  trace_checker #(.NUM_FRAMES(3), .CNT_W(CW)) dut (
    .base_clk(base_clk),
    .reset(reset),
    .step_valid(step_valid),
    .step_ready(step_ready),
    .snap_pc(snap_pc),
    .snap_inst(snap_inst),
    .snap_gpr(snap_gpr),
    .gold_valid(gold_valid),
    .gold_data(gold_data),
    .gold_ready(gold_ready),
    .frame_cnt(frame_cnt),
    .mismatch_cnt(mismatch_cnt),
    .first_err_valid(first_err_valid),
    .first_err_frame(first_err_frame),
    .first_err_idx(first_err_idx),
    .first_err_got(first_err_got),
    .first_err_exp(first_err_exp),
    .done(done)
  );

  always #5 base_clk = ~base_clk;

  typedef struct {
    logic [CW-1:0] frame;
    logic [CW-1:0] mis;
    logic          fev;
    logic [CW-1:0] ffr;
    logic [5:0]    fidx;
    logic [31:0]   fgot;
    logic [31:0]   fexp;
    logic          done;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [31:0] live_w [34];
  logic [31:0] gold_w [34];

  logic [CW-1:0] m_frame, m_mis, m_ffr;
  logic          m_fev, m_done;
  logic [5:0]    m_fidx;
  logic [31:0]   m_fgot, m_fexp;

  always @(posedge base_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic model_clear();
    m_frame = '0; m_mis = '0; m_fev = 1'b0; m_ffr = '0;
    m_fidx = '0; m_fgot = '0; m_fexp = '0; m_done = 1'b0;
    sb.delete();
  endtask

  task automatic push_word(input int i, output bit stop);
    exp_t e;
    bit   mis;
    mis  = (gold_w[i] != live_w[i]);
    stop = 1'b0;
    if (mis) begin
      if (m_mis != '1) m_mis++;
      if (!m_fev) begin
        m_fev  = 1'b1;
        m_ffr  = m_frame;
        m_fidx = i[5:0];
        m_fgot = live_w[i];
        m_fexp = gold_w[i];
      end
    end
`ifdef TRACE_CHECK_STOP_ON_ERR_EN
    stop = mis;
`endif
    if (stop) m_done = 1'b1;
    else if (i == 33) begin
      m_frame++;
      if (m_frame == 3) m_done = 1'b1;
    end
    e.frame = m_frame; e.mis = m_mis; e.fev = m_fev; e.ffr = m_ffr;
    e.fidx = m_fidx; e.fgot = m_fgot; e.fexp = m_fexp; e.done = m_done;
    sb.push_back(e);
  endtask

  // Monitor: every accepted golden word must match the next expected record.
  always begin
    exp_t e;
    @(posedge base_clk);
    if (gold_valid && gold_ready && !reset) begin
      @(negedge base_clk);
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL consume: got unexpected word %0h expected none",
                 gold_data);
      end else begin
        e = sb.pop_front();
        chk("sb_frame_cnt", frame_cnt, e.frame);
        chk("sb_mismatch_cnt", mismatch_cnt, e.mis);
        chk("sb_fe_valid", first_err_valid, e.fev);
        chk("sb_fe_frame", first_err_frame, e.ffr);
        chk("sb_fe_idx", first_err_idx, e.fidx);
        chk("sb_fe_got", first_err_got, e.fgot);
        chk("sb_fe_exp", first_err_exp, e.fexp);
        chk("sb_done", done, e.done);
      end
    end
  end

  task automatic set_live(input logic [31:0] pc, input logic [31:0] inst);
    live_w[0] = pc;
    live_w[1] = inst;
    for (int g = 0; g < 32; g++) live_w[2+g] = 32'(g);
    gold_w = live_w;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step_valid = 1'b0;
    gold_valid = 1'b0;
    repeat (2) @(negedge base_clk);
    reset = 1'b0;
    model_clear();
  endtask

  // Called at a negedge. Returns at the negedge following the last consume.
  task automatic do_frame(input bit bp, input int rst_at,
                          output int acc, output int last);
    int i;
    int guard;
    bit ph;
    bit stop;
    acc = cyc;
    last = cyc;
    gold_valid = 1'b0;
    guard = 0;
    while (!step_ready && guard < 100) begin
      @(negedge base_clk);
      guard++;
    end
    if (!step_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL step_wait: got step_ready 0 expected 1");
      return;
    end
    step_valid = 1'b1;
    snap_pc = live_w[0];
    snap_inst = live_w[1];
    for (int g = 0; g < 32; g++) snap_gpr[32*g +: 32] = live_w[2+g];
    @(negedge base_clk);
    acc = cyc;
    step_valid = 1'b0;
    snap_pc = $urandom;
    snap_inst = $urandom;
    snap_gpr = ~snap_gpr;
    i = 0;
    ph = 1'b1;
    stop = 1'b0;
    guard = 0;
    while (i < 34 && !stop && guard < 300) begin
      guard++;
      if (bp && !ph) begin
        gold_valid = 1'b0;
        gold_data = $urandom;
        step_valid = 1'b1;
      end else begin
        step_valid = 1'b0;
        gold_valid = 1'b1;
        gold_data = gold_w[i];
        if (i == rst_at) begin
          reset = 1'b1;
          @(negedge base_clk);
          reset = 1'b0;
          gold_valid = 1'b0;
          model_clear();
          last = cyc;
          return;
        end
        push_word(i, stop);
        i++;
      end
      ph = !ph;
      @(negedge base_clk);
    end
    last = cyc;
    if (i < 34 && !stop) begin
      n_chk++;
      n_fail++;
      $display("FAIL frame_timeout: got %0d words expected 34", i);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, acc, last;
    reset = 1'b1;
    step_valid = 1'b0;
    gold_valid = 1'b0;
    gold_data = '0;
    snap_pc = '0;
    snap_inst = '0;
    snap_gpr = '0;
    @(negedge base_clk);
    do_reset();

    chk("rst_step_ready", step_ready, 1);
    chk("rst_gold_ready", gold_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_mismatch_cnt", mismatch_cnt, 0);
    chk("rst_fe_valid", first_err_valid, 0);
    chk("rst_fe_frame", first_err_frame, 0);
    chk("rst_fe_idx", first_err_idx, 0);
    chk("rst_fe_got", first_err_got, 0);
    chk("rst_fe_exp", first_err_exp, 0);

    // Clean run of three back-to-back frames.
    set_live(32'h0040_0000, 32'h3C01_1001);
    do_frame(1'b0, -1, acc0, last);
    chk("a_f0_len", last - acc0, 34);
    do_frame(1'b0, -1, acc, last);
    chk("a_period", acc - acc0, 35);
    do_frame(1'b0, -1, acc, last);
    // done visible in cycle k+105, i.e. after edge k+104
    chk("a_done", done, 1);
    chk("a_done_time", cyc - acc0, 104);
    chk("a_frame_cnt", frame_cnt, 3);
    chk("a_mismatch_cnt", mismatch_cnt, 0);
    step_valid = 1'b1;
    gold_valid = 1'b1;
    repeat (3) @(negedge base_clk);
    chk("a_hold_step_ready", step_ready, 0);
    chk("a_hold_gold_ready", gold_ready, 0);
    chk("a_hold_done", done, 1);
    chk("a_hold_frame_cnt", frame_cnt, 3);
    step_valid = 1'b0;
    gold_valid = 1'b0;

`ifndef TRACE_CHECK_STOP_ON_ERR_EN
    // Single mismatch in frame 1, later one in frame 2.
    do_reset();
    set_live(32'h0040_0000, 32'h3C01_1001);
    do_frame(1'b0, -1, acc, last);
    gold_w[7] = 32'h6;
    do_frame(1'b0, -1, acc, last);
    chk("b_mismatch_cnt", mismatch_cnt, 1);
    chk("b_fe_valid", first_err_valid, 1);
    chk("b_fe_frame", first_err_frame, 1);
    chk("b_fe_idx", first_err_idx, 7);
    chk("b_fe_got", first_err_got, 32'h5);
    chk("b_fe_exp", first_err_exp, 32'h6);
    gold_w[7] = 32'h5;
    gold_w[3] = 32'hDEAD;
    do_frame(1'b0, -1, acc, last);
    chk("b2_mismatch_cnt", mismatch_cnt, 2);
    chk("b2_fe_frame", first_err_frame, 1);
    chk("b2_fe_idx", first_err_idx, 7);
    chk("b2_fe_got", first_err_got, 32'h5);
    chk("b2_fe_exp", first_err_exp, 32'h6);
    chk("b2_frame_cnt", frame_cnt, 3);
    chk("b2_done", done, 1);
`endif

    // Backpressure with ignored step_valid pulses.
    do_reset();
    set_live(32'h0040_0100, 32'h2402_0005);
    do_frame(1'b1, -1, acc, last);
    chk("c_len", last - acc, 67);
    chk("c_frame_cnt", frame_cnt, 1);
    chk("c_mismatch_cnt", mismatch_cnt, 0);
    chk("c_step_ready", step_ready, 1);

    // Reset after ten words, then a clean frame.
    do_reset();
    set_live(32'h0040_0200, 32'h0000_000C);
    do_frame(1'b0, 10, acc, last);
    chk("d_rst_frame_cnt", frame_cnt, 0);
    chk("d_rst_mismatch_cnt", mismatch_cnt, 0);
    chk("d_rst_step_ready", step_ready, 1);
    chk("d_rst_gold_ready", gold_ready, 0);
    do_frame(1'b0, -1, acc, last);
    chk("d_frame_cnt", frame_cnt, 1);
    chk("d_mismatch_cnt", mismatch_cnt, 0);

`ifdef TRACE_CHECK_STOP_ON_ERR_EN
    // Halt on first mismatch at idx 0.
    do_reset();
    set_live(32'h0040_0000, 32'h3C01_1001);
    gold_w[0] = 32'h0040_0004;
    do_frame(1'b0, -1, acc, last);
    chk("e_done", done, 1);
    chk("e_frame_cnt", frame_cnt, 0);
    chk("e_gold_ready", gold_ready, 0);
    chk("e_fe_idx", first_err_idx, 0);
    gold_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge base_clk);
      chk("e_hold_gold_ready", gold_ready, 0);
    end
    gold_valid = 1'b0;
    chk("e_hold_mismatch_cnt", mismatch_cnt, 1);
`endif

    repeat (2) @(negedge base_clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
